shift_count_register: RTL and testbench
=======================================

SHIFT_COUNT_REGISTER -- requirements
Module: shift_count_register

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, register width in bits (>= 2).
REQ-002 Parameter: SHAMT_WIDTH, default 4, width of the multi-bit shift amount; max shift is 2^SHAMT_WIDTH-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cl  input  1  clear register.
REQ-006 ld  input  1  parallel load from in.
REQ-007 in  input  DATA_WIDTH  load data.
REQ-008 inc / dec  input  1 each  increment / decrement by one.
REQ-009 sr / sl  input  1 each  single-bit shift right / left.
REQ-010 ir / il  input  1 each  fill bit for right / left shifts in mode 00.
REQ-011 mode  input  2  shift mode: 00 fill (ir/il), 01 arithmetic, 10 rotate, 11 treated as 00.
REQ-012 start  input  1  begin multi-cycle shift.
REQ-013 dir  input  1  multi-cycle direction: 0 right, 1 left.
REQ-014 shamt  input  SHAMT_WIDTH  multi-cycle shift amount.
REQ-015 out  output  DATA_WIDTH  register contents.
REQ-016 busy  output  1  multi-cycle shift in progress.
REQ-017 done  output  1  one-cycle pulse on multi-cycle shift completion.
REQ-018 carry  output  1  registered status: last shifted-out bit, or inc/dec wrap.
REQ-019 zero / neg  output  1 each  combinational: out == 0 / out[DATA_WIDTH-1].

Function
REQ-020 Two states, IDLE and SHIFT, shall be implemented; busy shall be 1 exactly when state is SHIFT.
REQ-021 In IDLE, controls shall be priority-decoded per edge: cl > ld > inc > dec > sr > sl > start; lower-priority controls in the same cycle shall be ignored; no control asserted holds out and carry.
REQ-022 cl: out <= 0, carry <= 0.  ld: out <= in, carry <= 0.
REQ-023 inc: out <= out+1 modulo 2^DATA_WIDTH; carry <= 1 iff out was all ones, else 0.
REQ-024 dec: out <= out-1 modulo 2^DATA_WIDTH; carry <= 1 iff out was zero, else 0.
REQ-025 Single-bit right shift, per mode: 00 MSB <= ir; 01 MSB <= old MSB; 10 MSB <= old LSB; carry <= old LSB.
REQ-026 Single-bit left shift, per mode: 00 LSB <= il; 01 LSB <= 0; 10 LSB <= old MSB; carry <= old MSB.
REQ-027 start in IDLE with shamt != 0: mode, dir, ir, il, shamt shall be latched at that edge (E0); state -> SHIFT; out unchanged at E0.
REQ-028 In SHIFT, each edge shall perform one single-bit shift per REQ-025/026 using the latched mode/dir/fill and decrement the latched count; after edge E(shamt), state -> IDLE.
REQ-029 A shift of N shall keep busy high for N cycles (E0..EN) and drive done high for the one cycle after EN; done is 0 otherwise.
REQ-030 start with shamt == 0: no state change, out and carry unchanged, busy stays 0, done pulses for the cycle after E0.
REQ-031 In SHIFT, cl shall abort: out <= 0, carry <= 0, state -> IDLE, no done pulse.
REQ-032 In SHIFT, ld, inc, dec, sr, sl, start and live mode/dir/shamt/ir/il changes shall be ignored.
REQ-033 done and start may coincide: a start in the cycle done is high shall be accepted normally (back-to-back).

Reset
REQ-034 rst_n low shall immediately force out=0, carry=0, busy=0, done=0, state IDLE, latched count 0, regardless of clk or any operation in progress.
REQ-035 After rst_n deasserts, the first rising edge shall be processed normally from IDLE.

Verification (DATA_WIDTH=16, SHAMT_WIDTH=4)
REQ-036 Reset: rst_n pulsed low mid-cycle -> out=0x0000, zero=1, busy=0, done=0, carry=0 asynchronously.
REQ-037 ld 0x8001, mode=01, sr -> out=0xC000, carry=1, neg=1; mode=10, sl -> out=0x8001, carry=1.
REQ-038 ld 0x00F0, start dir=1 mode=10 shamt=4 -> busy high 4 cycles, out=0x0F00, done one cycle, carry=0.
REQ-039 ld 0xFFFF, inc -> out=0x0000, carry=1, zero=1; dec -> out=0xFFFF, carry=1, neg=1; dec -> 0xFFFE, carry=0.
REQ-040 ld 0x1234, start shamt=8, cl in 3rd busy cycle -> out=0x0000, busy=0 next cycle, done never pulses; start shamt=0 -> done pulse, out unchanged.
REQ-041 start shamt=8 then rst_n low during SHIFT -> all outputs reset immediately; ld 0x00FF afterwards -> out=0x00FF.

Source files
------------

// File: rtl/shift_count_register_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_count_register_if
//  Description : Control/data bundle for shift_count_register. The master
//                side drives the operation controls and load data. The
//                slave side returns the register contents and status flags.
//  Signals     :
//      cl, ld, in         clear / parallel load / load data
//      inc, dec           increment / decrement by one
//      sr, sl             single-bit shift right / left
//      ir, il             fill bits for mode 00 shifts
//      mode               00 fill, 01 arithmetic, 10 rotate, 11 as 00
//      start, dir, shamt  multi-cycle shift request, direction, amount
//      out                register contents
//      busy, done         multi-cycle shift in progress / completion pulse
//      carry              last shifted-out bit or inc/dec wrap
//      zero, neg          out == 0 / out MSB
//  Revision    : 1.0 - initial release
// ============================================================================
interface shift_count_register_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int SHAMT_WIDTH = 4
);
    logic                   cl;
    logic                   ld;
    logic [DATA_WIDTH-1:0]  in;
    logic                   inc;
    logic                   dec;
    logic                   sr;
    logic                   sl;
    logic                   ir;
    logic                   il;
    logic [1:0]             mode;
    logic                   start;
    logic                   dir;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic [DATA_WIDTH-1:0]  out;
    logic                   busy;
    logic                   done;
    logic                   carry;
    logic                   zero;
    logic                   neg;

    modport master (
        output cl, ld, in, inc, dec, sr, sl, ir, il, mode, start, dir, shamt,
        input  out, busy, done, carry, zero, neg
    );

    modport slave (
        input  cl, ld, in, inc, dec, sr, sl, ir, il, mode, start, dir, shamt,
        output out, busy, done, carry, zero, neg
    );
endinterface
`default_nettype wire

// File: rtl/shift_count_register.sv
`default_nettype none
// ============================================================================
//  Module      : shift_count_register
//  Description : Register with clear, load, increment/decrement, single-bit
//                shifts in three modes and a multi-cycle shift engine that
//                shifts one bit per clock for a requested amount.
//  Ports       :
//      clk    in   single clock, rising edge
//      rst_n  in   asynchronous active-low reset
//      bus    slave modport of shift_count_register_if (controls in,
//             out/busy/done/carry/zero/neg out)
//  Parameters  :
//      DATA_WIDTH   register width (>= 2)
//      SHAMT_WIDTH  width of the multi-cycle shift amount
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_count_register #(
    parameter int DATA_WIDTH  = 16,
    parameter int SHAMT_WIDTH = 4
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    shift_count_register_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [DATA_WIDTH:0]    c_one_ext = {{DATA_WIDTH{1'b0}}, 1'b1};
    localparam logic [SHAMT_WIDTH-1:0] c_cnt_one = {{(SHAMT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q;
    logic [DATA_WIDTH-1:0]  out_q;
    logic                   carry_q;
    logic                   done_q;
    logic [SHAMT_WIDTH-1:0] cnt_q;
    logic [1:0]             mode_q;
    logic                   dir_q;
    logic                   ir_q;
    logic                   il_q;

    // {carry, value} results of one single-bit shift
    logic [DATA_WIDTH:0]    live_shr_d;
    logic [DATA_WIDTH:0]    live_shl_d;
    logic [DATA_WIDTH:0]    run_shift_d;
    logic [DATA_WIDTH:0]    inc_d;
    logic [DATA_WIDTH:0]    dec_d;

    // One-bit shift of v. Returns {shifted-out bit, new value}.
    // Mode 11 falls through to the fill behaviour of mode 00.
    function automatic logic [DATA_WIDTH:0] shift_one(
        input logic [DATA_WIDTH-1:0] v,
        input logic                  left,
        input logic [1:0]            md,
        input logic                  fill_r,
        input logic                  fill_l
    );
        logic fill;
        fill = 1'b0;
        if (!left) begin
            case (md)
                2'b01:   fill = v[DATA_WIDTH-1];
                2'b10:   fill = v[0];
                default: fill = fill_r;
            endcase
            shift_one = {v[0], fill, v[DATA_WIDTH-1:1]};
        end else begin
            case (md)
                2'b01:   fill = 1'b0;
                2'b10:   fill = v[DATA_WIDTH-1];
                default: fill = fill_l;
            endcase
            shift_one = {v[DATA_WIDTH-1], v[DATA_WIDTH-2:0], fill};
        end
    endfunction

    always_comb begin
        live_shr_d  = shift_one(out_q, 1'b0, bus.mode, bus.ir, bus.il);
        live_shl_d  = shift_one(out_q, 1'b1, bus.mode, bus.ir, bus.il);
        run_shift_d = shift_one(out_q, dir_q, mode_q, ir_q, il_q);
        // The extra top bit is the wrap indication: set on all-ones + 1
        // and on zero - 1 (borrow propagates into it).
        inc_d       = {1'b0, out_q} + c_one_ext;
        dec_d       = {1'b0, out_q} - c_one_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
            dir_q   <= 1'b0;
            ir_q    <= 1'b0;
            il_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.cl) begin
                        out_q   <= '0;
                        carry_q <= 1'b0;
                    end else if (bus.ld) begin
                        out_q   <= bus.in;
                        carry_q <= 1'b0;
                    end else if (bus.inc) begin
                        {carry_q, out_q} <= inc_d;
                    end else if (bus.dec) begin
                        {carry_q, out_q} <= dec_d;
                    end else if (bus.sr) begin
                        {carry_q, out_q} <= live_shr_d;
                    end else if (bus.sl) begin
                        {carry_q, out_q} <= live_shl_d;
                    end else if (bus.start) begin
                        if (bus.shamt == '0) begin
                            // Zero-length shift: acknowledge only.
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ST_SHIFT;
                            cnt_q   <= bus.shamt;
                            mode_q  <= bus.mode;
                            dir_q   <= bus.dir;
                            ir_q    <= bus.ir;
                            il_q    <= bus.il;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (bus.cl) begin
                        // Abort: no completion pulse.
                        state_q <= ST_IDLE;
                        out_q   <= '0;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        {carry_q, out_q} <= run_shift_d;
                        cnt_q            <= cnt_q - c_cnt_one;
                        if (cnt_q == c_cnt_one) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.out   = out_q;
    assign bus.carry = carry_q;
    assign bus.done  = done_q;
    assign bus.busy  = (state_q == ST_SHIFT);
    assign bus.zero  = (out_q == '0);
    assign bus.neg   = out_q[DATA_WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_shift_count_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_count_register
//  Description : Self-checking bench for shift_count_register (16/4). A
//                behavioural model predicts every output; a compare process
//                checks it on each falling clock edge, and directed steps
//                pin hand-computed literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_count_register;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    shift_count_register_if #(.DATA_WIDTH(16), .SHAMT_WIDTH(4)) bus_if ();

    shift_count_register #(.DATA_WIDTH(16), .SHAMT_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int       m_out   = 0;
    bit       m_carry = 1'b0;
    bit       m_busy  = 1'b0;
    bit       m_done  = 1'b0;
    int       m_left  = 0;
    int       m_mode  = 0;
    bit       m_dir   = 1'b0;
    bit       m_ir    = 1'b0;
    bit       m_il    = 1'b0;

    // One-bit shift using integer arithmetic on the 16-bit value.
    function automatic void m_shift(input bit left, input int md, input bit fr, input bit fl);
        int fill;
        if (!left) begin
            fill    = (md == 1) ? m_out / 32768 : (md == 2) ? m_out % 2 : int'(fr);
            m_carry = bit'(m_out % 2);
            m_out   = m_out / 2 + fill * 32768;
        end else begin
            fill    = (md == 1) ? 0 : (md == 2) ? m_out / 32768 : int'(fl);
            m_carry = bit'(m_out / 32768);
            m_out   = (m_out * 2) % 65536 + fill;
        end
    endfunction

    always @(negedge rst_n) begin
        m_out = 0; m_carry = 0; m_busy = 0; m_done = 0; m_left = 0;
    end

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (bus_if.cl) begin
                    m_out = 0; m_carry = 0;
                end else if (bus_if.ld) begin
                    m_out = int'(bus_if.in); m_carry = 0;
                end else if (bus_if.inc) begin
                    m_carry = (m_out == 65535);
                    m_out   = (m_out + 1) % 65536;
                end else if (bus_if.dec) begin
                    m_carry = (m_out == 0);
                    m_out   = (m_out + 65535) % 65536;
                end else if (bus_if.sr) begin
                    m_shift(1'b0, int'(bus_if.mode), bus_if.ir, bus_if.il);
                end else if (bus_if.sl) begin
                    m_shift(1'b1, int'(bus_if.mode), bus_if.ir, bus_if.il);
                end else if (bus_if.start) begin
                    if (bus_if.shamt == 0) begin
                        m_done = 1'b1;
                    end else begin
                        m_busy = 1'b1;
                        m_left = int'(bus_if.shamt);
                        m_mode = int'(bus_if.mode);
                        m_dir  = bus_if.dir;
                        m_ir   = bus_if.ir;
                        m_il   = bus_if.il;
                    end
                end
            end else begin
                if (bus_if.cl) begin
                    m_out = 0; m_carry = 0; m_busy = 0; m_left = 0;
                end else begin
                    m_shift(m_dir, m_mode, m_ir, m_il);
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (check_en) begin
            chk("model out",   32'(bus_if.out),   32'(m_out));
            chk("model carry", 32'(bus_if.carry), 32'(m_carry));
            chk("model busy",  32'(bus_if.busy),  32'(m_busy));
            chk("model done",  32'(bus_if.done),  32'(m_done));
            chk("model zero",  32'(bus_if.zero),  32'(m_out == 0));
            chk("model neg",   32'(bus_if.neg),   32'(m_out / 32768));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] v);
        bus_if.ld = 1'b1; bus_if.in = v;
        cyc();
        bus_if.ld = 1'b0;
    endtask

    initial begin
        bus_if.cl = 0; bus_if.ld = 0; bus_if.in = '0; bus_if.inc = 0; bus_if.dec = 0;
        bus_if.sr = 0; bus_if.sl = 0; bus_if.ir = 0; bus_if.il = 0; bus_if.mode = 2'b00;
        bus_if.start = 0; bus_if.dir = 0; bus_if.shamt = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        check_en = 1'b1;

        // Reset state
        chk("rst out",   32'(bus_if.out),   32'h0000);
        chk("rst zero",  32'(bus_if.zero),  32'h1);
        chk("rst busy",  32'(bus_if.busy),  32'h0);
        chk("rst done",  32'(bus_if.done),  32'h0);
        chk("rst carry", 32'(bus_if.carry), 32'h0);

        // Arithmetic right / rotate left
        load(16'h8001);
        chk("ld out", 32'(bus_if.out), 32'h8001);
        bus_if.mode = 2'b01; bus_if.sr = 1; cyc(); bus_if.sr = 0;
        chk("asr out",   32'(bus_if.out),   32'hC000);
        chk("asr carry", 32'(bus_if.carry), 32'h1);
        chk("asr neg",   32'(bus_if.neg),   32'h1);
        bus_if.mode = 2'b10; bus_if.sl = 1; cyc(); bus_if.sl = 0;
        chk("rol out",   32'(bus_if.out),   32'h8001);
        chk("rol carry", 32'(bus_if.carry), 32'h1);

        // Fill modes (00 and 11), arithmetic left ignores il
        load(16'h0003);
        bus_if.mode = 2'b00; bus_if.ir = 1; bus_if.sr = 1; cyc(); bus_if.sr = 0; bus_if.ir = 0;
        chk("fill sr out", 32'(bus_if.out), 32'h8001);
        bus_if.mode = 2'b11; bus_if.il = 1; bus_if.sl = 1; cyc(); bus_if.sl = 0;
        chk("mode11 sl out", 32'(bus_if.out), 32'h0003);
        bus_if.mode = 2'b01; bus_if.sl = 1; cyc(); bus_if.sl = 0; bus_if.il = 0;
        chk("asl out",   32'(bus_if.out),   32'h0006);
        chk("asl carry", 32'(bus_if.carry), 32'h0);

        // Priority: inc beats dec/sr/start; cl beats ld
        bus_if.inc = 1; bus_if.dec = 1; bus_if.sr = 1; bus_if.start = 1; bus_if.shamt = 4'd3;
        cyc();
        bus_if.inc = 0; bus_if.dec = 0; bus_if.sr = 0; bus_if.start = 0; bus_if.shamt = '0;
        chk("prio inc out", 32'(bus_if.out),  32'h0007);
        chk("prio busy",    32'(bus_if.busy), 32'h0);
        bus_if.cl = 1; bus_if.ld = 1; bus_if.in = 16'hFFFF; cyc(); bus_if.cl = 0; bus_if.ld = 0;
        chk("prio cl out", 32'(bus_if.out), 32'h0000);

        // Multi-cycle rotate left by 4
        load(16'h00F0);
        bus_if.start = 1; bus_if.dir = 1; bus_if.mode = 2'b10; bus_if.shamt = 4'd4;
        cyc();
        bus_if.start = 0; bus_if.dir = 0; bus_if.mode = 2'b00; bus_if.shamt = '0;
        chk("mc E0 busy", 32'(bus_if.busy), 32'h1);
        chk("mc E0 out",  32'(bus_if.out),  32'h00F0);
        bus_if.ld = 1; bus_if.in = 16'hFFFF; cyc(); bus_if.ld = 0;
        chk("mc E1 out",  32'(bus_if.out),  32'h01E0);
        cyc();
        cyc();
        chk("mc E3 busy", 32'(bus_if.busy), 32'h1);
        chk("mc E3 out",  32'(bus_if.out),  32'h0780);
        cyc();
        chk("mc E4 busy",  32'(bus_if.busy),  32'h0);
        chk("mc E4 done",  32'(bus_if.done),  32'h1);
        chk("mc E4 out",   32'(bus_if.out),   32'h0F00);
        chk("mc E4 carry", 32'(bus_if.carry), 32'h0);
        cyc();
        chk("mc done drop", 32'(bus_if.done), 32'h0);

        // Increment / decrement wrap
        load(16'hFFFF);
        bus_if.inc = 1; cyc(); bus_if.inc = 0;
        chk("inc out",   32'(bus_if.out),   32'h0000);
        chk("inc carry", 32'(bus_if.carry), 32'h1);
        chk("inc zero",  32'(bus_if.zero),  32'h1);
        bus_if.dec = 1; cyc();
        chk("dec out",   32'(bus_if.out),   32'hFFFF);
        chk("dec carry", 32'(bus_if.carry), 32'h1);
        chk("dec neg",   32'(bus_if.neg),   32'h1);
        cyc(); bus_if.dec = 0;
        chk("dec2 out",   32'(bus_if.out),   32'hFFFE);
        chk("dec2 carry", 32'(bus_if.carry), 32'h0);

        // Abort with cl in the third busy cycle
        load(16'h1234);
        bus_if.start = 1; bus_if.dir = 0; bus_if.mode = 2'b00; bus_if.ir = 0; bus_if.shamt = 4'd8;
        cyc();
        bus_if.start = 0; bus_if.shamt = '0;
        cyc();
        cyc();
        chk("abort pre out", 32'(bus_if.out), 32'h048D);
        bus_if.cl = 1; cyc(); bus_if.cl = 0;
        chk("abort out",  32'(bus_if.out),  32'h0000);
        chk("abort busy", 32'(bus_if.busy), 32'h0);
        chk("abort done", 32'(bus_if.done), 32'h0);
        cyc();
        chk("abort done2", 32'(bus_if.done), 32'h0);

        // Zero-length start, then back-to-back start while done is high
        load(16'hABCD);
        bus_if.start = 1; bus_if.shamt = '0; cyc();
        chk("sh0 done",  32'(bus_if.done),  32'h1);
        chk("sh0 busy",  32'(bus_if.busy),  32'h0);
        chk("sh0 out",   32'(bus_if.out),   32'hABCD);
        chk("sh0 carry", 32'(bus_if.carry), 32'h0);
        bus_if.shamt = 4'd1; bus_if.dir = 0; bus_if.mode = 2'b10; cyc();
        bus_if.start = 0; bus_if.shamt = '0;
        chk("b2b busy", 32'(bus_if.busy), 32'h1);
        chk("b2b done", 32'(bus_if.done), 32'h0);
        cyc();
        chk("b2b out",   32'(bus_if.out),   32'hD5E6);
        chk("b2b carry", 32'(bus_if.carry), 32'h1);
        chk("b2b done2", 32'(bus_if.done),  32'h1);

        // Asynchronous reset during a shift
        bus_if.start = 1; bus_if.dir = 1; bus_if.mode = 2'b00; bus_if.il = 1; bus_if.shamt = 4'd8;
        cyc();
        bus_if.start = 0; bus_if.shamt = '0; bus_if.il = 0;
        cyc();
        chk("pre rst out",  32'(bus_if.out),  32'hABCD);
        chk("pre rst busy", 32'(bus_if.busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async out",   32'(bus_if.out),   32'h0000);
        chk("async zero",  32'(bus_if.zero),  32'h1);
        chk("async busy",  32'(bus_if.busy),  32'h0);
        chk("async done",  32'(bus_if.done),  32'h0);
        chk("async carry", 32'(bus_if.carry), 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        load(16'h00FF);
        chk("post rst out",  32'(bus_if.out),  32'h00FF);
        chk("post rst busy", 32'(bus_if.busy), 32'h0);
        cyc();
        cyc();

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
